// File: rtl/reg_dump_tx.sv
// reg_dump_tx: snapshots r0-r5 on trigger and streams a framed, checksummed byte dump over valid/ready.
module reg_dump_tx #(
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        trigger,
  input  logic [31:0] r0,
  input  logic [31:0] r1,
  input  logic [31:0] r2,
  input  logic [31:0] r3,
  input  logic [31:0] r4,
  input  logic [31:0] r5,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, HDR, SEQ, DATA, CSUM} state_t;
  state_t state, state_n;
  logic [191:0] snap, shifted;
  logic [4:0] idx;
  logic [7:0] seq, csum, data_byte;
  logic xfer;
  assign out_valid = state != IDLE;
  assign out_last = state == CSUM;
  assign xfer = out_valid && out_ready;
  // r0 occupies the top of the snapshot, so shifting left by idx bytes yields the next big-endian byte
  always_comb begin
    shifted = snap << {idx, 3'b000};
    data_byte = shifted[191:184];
    out_data = state == HDR  ? HEADER :
               state == SEQ  ? seq :
               state == DATA ? data_byte :
               state == CSUM ? csum : 8'h00;
    state_n = state;
    case (state)
      IDLE:    state_n = trigger ? HDR : IDLE;
      HDR:     state_n = out_ready ? SEQ : HDR;
      SEQ:     state_n = out_ready ? DATA : SEQ;
      DATA:    state_n = out_ready && idx == 5'd23 ? CSUM : DATA;
      CSUM:    state_n = out_ready ? IDLE : CSUM;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      busy <= state_n != IDLE;
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      snap <= '0;
      idx <= '0;
      seq <= '0;
      csum <= '0;
    end else if (state == IDLE && trigger) begin
      snap <= {r0, r1, r2, r3, r4, r5};
      csum <= '0;
    end else if (xfer) begin
      idx <= state == DATA ? idx + 5'd1 : 5'd0;
      csum <= state == SEQ ? csum + seq : state == DATA ? csum + data_byte : csum;
      seq <= state == CSUM ? seq + 8'd1 : seq;
    end
  end
endmodule

// File: tb/tb_reg_dump_tx.sv
// tb_reg_dump_tx: table-driven frame checks plus reset, wrap and async-abort sequences for reg_dump_tx.
module tb_reg_dump_tx;
  logic clock = 1'b0;
  logic reset_n, trigger, out_ready, out_valid, out_last, busy;
  logic [31:0] r0, r1, r2, r3, r4, r5;
  logic [7:0] out_data;
  int checks = 0;
  int fails = 0;

  typedef struct {
    logic [5:0][31:0] r;
    int stall_a;
    int stall_b;
    bit mid_trig;
    bit end_trig;
    bit mod_r0;
    logic [7:0] seq;
    logic [7:0] csum;
    int cycles;
  } vec_t;
  vec_t vecs [8];
  vec_t v;

  reg_dump_tx dut (
    .clock(clock), .reset_n(reset_n), .trigger(trigger),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #3_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_frame(input vec_t f);
    logic [7:0] exp_b [27];
    logic [7:0] got [27];
    logic [7:0] held;
    bit stalled, held_last;
    int n, cyc, stall_n, bad_data, bad_last, bad_valid, bad_hold, extra;
    exp_b[0] = 8'hA5;
    exp_b[1] = f.seq;
    for (int i = 0; i < 24; i++) exp_b[2 + i] = f.r[i / 4][31 - 8 * (i % 4) -: 8];
    exp_b[26] = f.csum;
    n = 0; cyc = 0; stall_n = 0; stalled = 0; held = '0; held_last = 0;
    bad_data = 0; bad_last = 0; bad_valid = 0; bad_hold = 0; extra = 0;
    @(negedge clock);
    {r5, r4, r3, r2, r1, r0} = f.r;
    trigger = 1'b1;
    out_ready = 1'b1;
    @(negedge clock);
    while (n < 27 && cyc < 100) begin
      trigger = (f.mid_trig && n == 10) || (f.end_trig && n == 26);
      if (f.mod_r0 && cyc == 0) r0 = 32'hFFFF_FFFF;
      if (!out_valid) bad_valid++;
      if (out_last != (n == 26)) bad_last++;
      if (stalled && (out_data != held || out_last != held_last)) bad_hold++;
      held = out_data;
      held_last = out_last;
      if ((n == f.stall_a || n == f.stall_b) && stall_n < 3) begin
        out_ready = 1'b0;
        stalled = 1;
        stall_n++;
      end else begin
        out_ready = 1'b1;
        got[n] = out_data;
        if (out_data != exp_b[n]) begin
          if (bad_data == 0) $display("FAIL byte_%0d: got %0h expected %0h", n, out_data, exp_b[n]);
          bad_data++;
        end
        n++;
        stalled = 0;
        stall_n = 0;
      end
      @(negedge clock);
      cyc++;
    end
    trigger = 1'b0;
    out_ready = 1'b1;
    check("frame_cycles", cyc, f.cycles);
    check("frame_bad_bytes", bad_data, 0);
    check("frame_seq", got[1], f.seq);
    check("frame_csum", got[26], f.csum);
    check("frame_last_bad", bad_last, 0);
    check("frame_valid_drop", bad_valid, 0);
    check("frame_stall_hold", bad_hold, 0);
    check("idle_after_frame", {out_valid, busy}, 0);
    if (f.mid_trig || f.end_trig) begin
      repeat (4) begin
        @(negedge clock);
        if (out_valid || busy) extra++;
      end
      check("no_extra_frame", extra, 0);
    end
  endtask

  initial begin
    reset_n = 1'b0; trigger = 1'b0; out_ready = 1'b1;
    {r0, r1, r2, r3, r4, r5} = '0;
    for (int i = 0; i < 8; i++) begin
      vecs[i].r = '0;
      vecs[i].r[0] = 32'd28; vecs[i].r[1] = 32'd29; vecs[i].r[2] = 32'd30; vecs[i].r[3] = 32'd31;
      vecs[i].stall_a = -1; vecs[i].stall_b = -1;
      vecs[i].mid_trig = 0; vecs[i].end_trig = 0; vecs[i].mod_r0 = 0;
      vecs[i].cycles = 27;
    end
    vecs[0].seq = 8'h00; vecs[0].csum = 8'h76;
    vecs[1].seq = 8'h01; vecs[1].csum = 8'h77; vecs[1].end_trig = 1;
    vecs[2].seq = 8'h02; vecs[2].csum = 8'h78; vecs[2].stall_a = 7; vecs[2].stall_b = 26; vecs[2].cycles = 33;
    vecs[3].seq = 8'h03; vecs[3].csum = 8'h79; vecs[3].mod_r0 = 1;
    vecs[4].seq = 8'h04; vecs[4].csum = 8'h7A; vecs[4].mid_trig = 1;
    vecs[5].r = '0; vecs[5].r[0] = 32'h0102_0304; vecs[5].seq = 8'h05; vecs[5].csum = 8'h0F;
    vecs[6].r = '1; vecs[6].seq = 8'h06; vecs[6].csum = 8'hEE;
    vecs[7].r = '0; vecs[7].r[5] = 32'h8080_8080; vecs[7].seq = 8'h07; vecs[7].csum = 8'h07;

    repeat (3) @(negedge clock);
    check("reset_outputs", {out_valid, out_last, busy, out_data}, 0);
    reset_n = 1'b1;
    @(negedge clock);
    check("idle_after_release", {out_valid, busy}, 0);

    for (int i = 0; i < 8; i++) do_frame(vecs[i]);

    for (int f = 8; f <= 256; f++) begin
      v = vecs[7];
      v.r = '0;
      v.seq = 8'(f);
      v.csum = 8'(f);
      do_frame(v);
    end

    @(negedge clock);
    trigger = 1'b1;
    @(negedge clock);
    trigger = 1'b0;
    repeat (12) @(negedge clock);
    check("abort_in_frame", {out_valid, busy}, 2'b11);
    #2 reset_n = 1'b0;
    #1 check("abort_async_drop", {out_valid, busy, out_last, out_data}, 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    check("no_partial_frame", {out_valid, busy}, 0);
    do_frame(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/reg_dump_tx.md
# reg_dump_tx

Register-dump transmitter for the processor's register file: the outbound counterpart to the instruction-load path. Program words go into the processor through addr/wEn/wDat; this block carries state back out. On a trigger it takes a snapshot of r0–r5 and streams it as a framed byte sequence over a valid/ready handshake. It sits beside `processor`, taps its r0–r5 outputs, and feeds a byte-wide sink such as a UART TX FIFO or a bench monitor.

## Interface
Parameters:
- HEADER, 8'hA5, first byte of every frame

Ports:
- clock  input  1  system clock, 50 MHz; all state changes on the rising edge
- reset_n  input  1  asynchronous, active-low reset
- trigger  input  1  request a dump; sampled only in IDLE
- r0..r5  input  32 each  processor register values
- out_ready  input  1  sink can accept a byte this cycle
- out_valid  output  1  out_data holds a valid byte
- out_data  output  8  frame byte
- out_last  output  1  high with the checksum byte, the final byte of the frame
- busy  output  1  high whenever the block is not in IDLE

## Operation
- Frame is 27 bytes, in this order:
  - HEADER
  - SEQ
  - 24 data bytes: r0..r5 in order, each register big-endian (MSB byte first)
  - CSUM
- SEQ is an 8-bit frame counter.
  - Resets to 0.
  - Increments by 1 after each completed frame, wrapping 255 -> 0.
- CSUM is the mod-256 sum of SEQ and the 24 data bytes. HEADER is excluded.
- Snapshot behaviour:
  - r0..r5 are latched into an internal 192-bit snapshot on the edge where trigger is accepted.
  - Register changes after that edge do not affect the frame in flight.
- State machine:
  - IDLE -> HDR on trigger=1.
  - HDR -> SEQ on transfer.
  - SEQ -> DATA on transfer.
  - DATA -> DATA while byte index < 23. DATA -> CSUM on transfer of index 23.
  - CSUM -> IDLE on transfer.
- A transfer occurs on a rising edge where out_valid && out_ready.
- Data byte index is a 5-bit counter, 0..23. It resets to 0 on entry to DATA.
- Handshake rules:
  - out_valid=1 in HDR, SEQ, DATA and CSUM; 0 in IDLE.
  - While out_valid && !out_ready, out_data, out_last and the state hold unchanged.
  - out_valid never drops before its transfer completes.
- trigger while busy is ignored, not queued.
- The running checksum accumulates on each SEQ and DATA transfer and clears on entry to HDR.

## Timing
- Reset values (asserted asynchronously):
  - state = IDLE
  - out_valid = 0, out_data = 8'h00, out_last = 0, busy = 0
  - SEQ = 0, checksum = 0, snapshot = 0
- Trigger latency: trigger=1 at edge N, in IDLE -> out_valid=1 and out_data=HEADER from just after edge N.
- With out_ready held at 1:
  - One byte transfers per cycle, so the frame occupies 27 consecutive cycles.
  - The CSUM transfer happens at edge N+27. The state is IDLE after that edge.
- Earliest next frame: trigger sampled at edge N+28.
  - A trigger at edge N+27 is ignored, because the state is still CSUM at that edge.
- out_last=1 only while in CSUM.
- busy is registered and equals (state != IDLE).
- Reset mid-frame:
  - The frame is aborted immediately and out_valid falls asynchronously.
  - SEQ returns to 0.
  - There is no partial-frame completion after reset is released.

## Test plan
- Basic dump: reset, then r0..r5 = 28, 29, 30, 31, 0, 0, out_ready=1, pulse trigger.
  - Required bytes: A5 00 | 00 00 00 1C | 00 00 00 1D | 00 00 00 1E | 00 00 00 1F | 8×00 | 76.
  - out_last is high only on 76.
- Back-to-back frames: trigger again after the first frame completes.
  - SEQ = 01 and CSUM = 77.
  - busy is low for at least one cycle between the two frames.
- Backpressure: drop out_ready for 3 cycles on data index 5 and again on CSUM.
  - out_data/out_last hold steady throughout each stall.
  - The frame content is identical to the basic dump, and the frame takes 33 cycles.
- Snapshot isolation: change r0 to 32'hFFFFFFFF one cycle after trigger.
  - The frame still carries 00 00 00 1C for r0, and CSUM is unchanged.
- Ignored trigger and wrap:
  - Pulse trigger mid-frame -> no extra frame.
  - Run 256 frames -> SEQ goes 00..FF then 00.
- Async reset mid-frame: assert reset_n=0 at data index 10, between clock edges.
  - out_valid/busy fall at once.
  - After release, the next trigger produces SEQ=00 and a full 27-byte frame.
